// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter between a CPU and a VGA fetcher, VGA-first.
// Define DMEM_ARB_STARVE_GUARD_EN to bound consecutive contested VGA grants at VGA_BURST_MAX.
module dmem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int VGA_BURST_MAX = 8
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // State bits double as the rvalid outputs, so the outputs come straight off flops.
  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_CPU  = 2'b01,
    RESP_VGA  = 2'b10
  } resp_state_t;

  resp_state_t resp_state;
  logic        starved;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int RUN_W = $clog2(VGA_BURST_MAX + 1);

  logic [RUN_W-1:0] vga_run;

  assign starved = (vga_run == RUN_W'(VGA_BURST_MAX));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      vga_run <= '0;
    end else if (cpu_gnt || !cpu_req) begin
      vga_run <= '0;
    end else if (vga_gnt) begin
      vga_run <= vga_run + RUN_W'(1);
    end
  end
`else
  logic unused_burst_max;
  assign unused_burst_max = ^VGA_BURST_MAX;
  assign starved          = 1'b0;
`endif

  // Read data is wired to both requesters outside this block; rvalid tells them whose it is.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  assign vga_gnt = resetn & vga_req & ~starved;
  assign cpu_gnt = resetn & cpu_req & ~vga_gnt;
  assign mem_en  = cpu_gnt | vga_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (vga_gnt) begin
      mem_be   = 4'hF;
      mem_addr = vga_addr;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_be    = cpu_be;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      resp_state <= RESP_NONE;
    end else if (cpu_gnt && !cpu_we) begin
      resp_state <= RESP_CPU;
    end else if (vga_gnt) begin
      resp_state <= RESP_VGA;
    end else begin
      resp_state <= RESP_NONE;
    end
  end

  assign cpu_rvalid = resp_state[0];
  assign vga_rvalid = resp_state[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed checks of dmem_arbiter against a behavioural model.
module tb_dmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int BURST  = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              CLOCK_50 = 1'b0;
  logic              resetn   = 1'b0;
  logic              cpu_req  = 1'b0;
  logic              cpu_we   = 1'b0;
  logic [3:0]        cpu_be   = 4'h0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [31:0]       cpu_wdata = 32'h0;
  logic              vga_req  = 1'b0;
  logic [ADDR_W-1:0] vga_addr = '0;
  logic [31:0]       mem_rdata = 32'h0;
  logic              cpu_gnt, cpu_rvalid, vga_gnt, vga_rvalid;
  logic              mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  dmem_arbiter #(.ADDR_W(ADDR_W), .VGA_BURST_MAX(BURST)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: length of the current run of VGA wins over a waiting CPU,
  // and which requester is owed read data next cycle.
  int m_run    = 0;
  bit exp_crv  = 1'b0;
  bit exp_vrv  = 1'b0;
  bit eg_c, eg_v;
  bit seen_cpu, seen_vga;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic drop_reset();
    resetn  = 1'b0;
    m_run   = 0;
    exp_crv = 1'b0;
    exp_vrv = 1'b0;
  endtask

  // Inputs are stable before this is called; checks at negedge, model advances at posedge.
  task automatic cycle();
    logic [69:0] exp_bus;
    bit starve;
    @(negedge CLOCK_50);
    starve = GUARD && (m_run >= BURST);
    eg_v   = resetn && vga_req && !starve;
    eg_c   = resetn && cpu_req && !eg_v;
    if (eg_v)      exp_bus = {1'b1, 1'b0, 4'hF, vga_addr, 32'h0};
    else if (eg_c) exp_bus = {1'b1, cpu_we, cpu_be, cpu_addr, cpu_wdata};
    else           exp_bus = '0;
    seen_cpu = cpu_gnt;
    seen_vga = vga_gnt;
    check("cpu_gnt", cpu_gnt, eg_c);
    check("vga_gnt", vga_gnt, eg_v);
    check("mem_bus", {mem_en, mem_we, mem_be, mem_addr, mem_wdata}, exp_bus);
    check("cpu_rvalid", cpu_rvalid, exp_crv);
    check("vga_rvalid", vga_rvalid, exp_vrv);
    @(posedge CLOCK_50);
    if (!resetn) begin
      m_run = 0; exp_crv = 1'b0; exp_vrv = 1'b0;
    end else begin
      exp_crv = eg_c && !cpu_we;
      exp_vrv = eg_v;
      if (eg_c || !cpu_req) m_run = 0;
      else if (eg_v)        m_run = m_run + 1;
    end
    mem_rdata = $urandom;
    #1;
  endtask

  initial begin
    int n_vga, first_cpu, n_cpu;
    // Reset state with both requesters asserting.
    cpu_req = 1'b1; vga_req = 1'b1; cpu_addr = 32'h44; vga_addr = 32'h88;
    cycle();
    cycle();
    resetn = 1'b1; cpu_req = 1'b0; vga_req = 1'b0;
    cycle();

    // Lone CPU read at 0x10.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 32'h10;
    cycle();
    cpu_req = 1'b0;
    cycle();
    cycle();

    // CPU write: byte enables pass through, no read response.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'b0011; cpu_addr = 32'h20; cpu_wdata = 32'hDEADBEEF;
    cycle();
    cpu_req = 1'b0; cpu_we = 1'b0;
    cycle();
    cycle();

    // Sustained contention.
    cpu_req = 1'b1; vga_req = 1'b1; cpu_addr = 32'h30; vga_addr = 32'h1000;
    n_vga = 0; first_cpu = -1; n_cpu = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (seen_cpu) n_cpu++;
      if (seen_cpu && first_cpu < 0) first_cpu = i;
      if (seen_vga && first_cpu < 0) n_vga++;
      vga_addr = vga_addr + 32'd4;
    end
    check("contend_vga_first", n_vga, GUARD ? BURST : 20);
    check("contend_cpu_slot", first_cpu, GUARD ? BURST : -1);
    check("contend_cpu_count", n_cpu, GUARD ? 20 / (BURST + 1) : 0);
    cpu_req = 1'b0; vga_req = 1'b0;
    cycle();

    // Reset asserted the cycle after a VGA grant drops its response.
    vga_req = 1'b1; vga_addr = 32'h2000;
    cycle();
    check("pre_reset_vga_gnt", seen_vga, 1'b1);
    drop_reset();
    vga_req = 1'b0;
    cycle();
    resetn = 1'b1;
    cycle();
    cycle();

    // Randomized traffic with requests withdrawn and occasional mid-run resets.
    for (int i = 0; i < 600; i++) begin
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 63) == 0) drop_reset();
      if (!(cpu_req && !seen_cpu && $urandom_range(0, 9) != 0)) begin
        cpu_req   = ($urandom_range(0, 2) != 0);
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_be    = 4'($urandom);
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
      end
      vga_req  = ($urandom_range(0, 4) != 0);
      vga_addr = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width of both requesters and the memory port.
REQ-002 SHALL have parameter VGA_BURST_MAX, default 8, consecutive contested VGA grants allowed before a forced CPU grant.
REQ-003 SHALL have port CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_req  in  1  CPU access request, held until cpu_gnt.
REQ-006 SHALL have port cpu_we  in  1  CPU write (1) / read (0).
REQ-007 SHALL have port cpu_be  in  4  CPU byte enables.
REQ-008 SHALL have port cpu_addr  in  ADDR_W  CPU address.
REQ-009 SHALL have port cpu_wdata  in  32  CPU write data.
REQ-010 SHALL have port cpu_gnt  out  1  CPU access issued this cycle.
REQ-011 SHALL have port cpu_rvalid  out  1  mem_rdata holds CPU read data.
REQ-012 SHALL have port vga_req  in  1  VGA pixel-fetch request, read only.
REQ-013 SHALL have port vga_addr  in  ADDR_W  VGA fetch address.
REQ-014 SHALL have port vga_gnt  out  1  VGA access issued this cycle.
REQ-015 SHALL have port vga_rvalid  out  1  mem_rdata holds VGA read data.
REQ-016 SHALL have port mem_en  out  1  single-port memory access strobe.
REQ-017 SHALL have port mem_we  out  1  memory write enable.
REQ-018 SHALL have port mem_be  out  4  memory byte enables.
REQ-019 SHALL have port mem_addr  out  ADDR_W  memory address.
REQ-020 SHALL have port mem_wdata  out  32  memory write data.
REQ-021 SHALL have port mem_rdata  in  32  memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-022 SHALL grant combinationally each cycle: VGA if vga_req and not starved; else CPU if cpu_req; else none; at most one grant.
REQ-023 SHALL drive mem_en = cpu_gnt | vga_gnt; mem_addr/mem_we/mem_be/mem_wdata from the granted requester.
REQ-024 SHALL drive a VGA access as mem_we=0, mem_be=4'hF, mem_wdata=0.
REQ-025 SHALL drive mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0 when no grant.
REQ-026 SHALL hold a response FSM with states RESP_NONE, RESP_CPU, RESP_VGA, loaded every cycle: RESP_CPU after a CPU read grant, RESP_VGA after a VGA grant, else RESP_NONE.
REQ-027 SHALL assert cpu_rvalid iff state RESP_CPU and vga_rvalid iff state RESP_VGA; exactly one cycle per read grant.
REQ-028 SHALL produce no rvalid for a CPU write; a write is complete at its grant cycle.
REQ-029 SHALL keep counter vga_run (width clog2(VGA_BURST_MAX+1)): +1 on each VGA grant while cpu_req=1; cleared on CPU grant or when cpu_req=0.
REQ-030 SHALL treat VGA as starved-out when vga_run == VGA_BURST_MAX, forcing a CPU grant that cycle.
REQ-031 SHALL accept requests dropped before grant without side effects.
REQ-032 SHALL not forward data; a read following a write to the same address returns what memory returns.
REQ-033 SHALL sustain back-to-back grants, one access per cycle, no idle bubble.

Reset
REQ-034 SHALL on resetn=0 immediately force FSM to RESP_NONE, vga_run=0, cpu_rvalid=0, vga_rvalid=0; grants and mem_* follow REQ-022..025 from inputs, gated to 0 while resetn=0.
REQ-035 SHALL discard any outstanding read response when reset asserts mid-access; no rvalid after reset release without a new grant.

Configuration
REQ-036 SHALL with DMEM_ARB_STARVE_GUARD_EN defined implement REQ-029/030; without it, omit vga_run and use strict VGA priority.

Verification
REQ-037 SHALL cover: cpu_req read addr 0x10 alone -> cpu_gnt cycle N, mem_addr=0x10, cpu_rvalid cycle N+1 only.
REQ-038 SHALL cover: cpu_req and vga_req together, VGA_BURST_MAX=8 -> 8 VGA grants, CPU grant 9th cycle, vga_run=0 afterwards.
REQ-039 SHALL cover: same as REQ-038 without DMEM_ARB_STARVE_GUARD_EN -> CPU never granted while vga_req=1.
REQ-040 SHALL cover: CPU write be=4'b0011 wdata=0xDEADBEEF -> mem_we=1, mem_be=4'b0011 at grant, no cpu_rvalid.
REQ-041 SHALL cover: resetn low the cycle after a VGA read grant -> vga_rvalid stays 0, FSM RESP_NONE.
